// File: rtl/branch_predictor.sv
// branch_predictor: fetch-stage PC owner with a direct-mapped BTB and
// saturating direction counters. Predicts the next fetch address in the same
// cycle, redirects fetch on an execute-stage misprediction, and keeps
// branch/misprediction statistics.
module branch_predictor #(
    parameter logic [31:0] PC_INIT  = 32'h0000_0000,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_en,
    output logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    output logic        flush,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    // Weakly taken: MSB set, rest clear. Weakly not-taken: MSB clear, rest set.
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_MAX >> 1;

    logic [31:0]         pc_q;
    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [31:0]         branch_cnt_q;
    logic [31:0]         mispred_cnt_q;

    logic [IDX_W-1:0]    f_idx, r_idx;
    logic [TAG_W-1:0]    f_tag, r_tag;
    logic                f_hit, r_hit;
    logic                mispredict;
    logic [31:0]         redirect_pc;
    logic [CTR_BITS-1:0] r_ctr, ctr_inc, ctr_dec;

    assign fetch_pc         = pc_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;

    // Combinational BTB lookup on the current fetch PC
    always_comb begin
        f_idx       = pc_q[IDX_W+1:2];
        f_tag       = pc_q[31:IDX_W+2];
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = f_hit && ctr_q[f_idx][CTR_BITS-1];
        pred_target = pred_taken ? target_q[f_idx] : pc_q + 32'd4;
    end

    // Misprediction detection, redirect address and counter saturation math
    always_comb begin
        r_idx       = res_pc[IDX_W+1:2];
        r_tag       = res_pc[31:IDX_W+2];
        r_hit       = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
        mispredict  = res_valid &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && (res_target != res_pred_target)));
        flush       = mispredict;
        redirect_pc = res_taken ? res_target : res_pc + 32'd4;
        r_ctr       = ctr_q[r_idx];
        ctr_inc     = (r_ctr == CTR_MAX) ? r_ctr : r_ctr + CTR_BITS'(1);
        ctr_dec     = (r_ctr == '0) ? r_ctr : r_ctr - CTR_BITS'(1);
    end

    // PC register: reset, then redirect, then predicted advance
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q <= PC_INIT;
        end else if (mispredict) begin
            pc_q <= redirect_pc;
        end else if (pc_en) begin
            pc_q <= pred_target;
        end
    end

    // BTB training on resolved control instructions
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (res_valid) begin
            if (r_hit) begin
                if (res_taken) begin
                    ctr_q[r_idx]    <= ctr_inc;
                    target_q[r_idx] <= res_target;
                end else begin
                    ctr_q[r_idx]    <= ctr_dec;
                end
            end else if (res_taken) begin
                // Allocate, evicting any aliasing entry
                valid_q[r_idx]  <= 1'b1;
                tag_q[r_idx]    <= r_tag;
                target_q[r_idx] <= res_target;
                ctr_q[r_idx]    <= CTR_WT;
            end
        end
    end

    // Statistics counters, wrapping modulo 2^32
    always_ff @(posedge CLK) begin
        if (RST) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (res_valid) branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with default parameters.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        pc_en = 1'b0;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        res_pred_taken = 1'b0;
    logic [31:0] res_pred_target = '0;
    logic        flush;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_vec = 0;
    int n_err = 0;
    logic last_flush;

    branch_predictor #(
        .PC_INIT  (32'h0),
        .ENTRIES  (16),
        .CTR_BITS (2)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .pc_en            (pc_en),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .res_pred_taken   (res_pred_taken),
        .res_pred_target  (res_pred_target),
        .flush            (flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // One resolution cycle; flush is captured mid-cycle for the caller
    task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
        @(negedge CLK);
        res_valid       = 1'b1;
        res_pc          = pc;
        res_taken       = taken;
        res_target      = tgt;
        res_pred_taken  = ptaken;
        res_pred_target = ptgt;
        #1;
        last_flush = flush;
        @(posedge CLK);
        #1;
        res_valid = 1'b0;
    endtask

    // Steer fetch_pc via a not-taken mispredict at addr-4 (index 15, never allocated)
    task automatic goto_pc(input logic [31:0] addr);
        resolve(addr - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (fetch_pc !== 32'h0) begin
            n_err++; $display("FAIL reset_pc: got %h want %h", fetch_pc, 32'h0);
        end
        n_vec++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h4) begin
            n_err++; $display("FAIL reset_pred: got %b/%h want 0/%h", pred_taken, pred_target, 32'h4);
        end
        n_vec++;
        if (flush !== 1'b0 || branch_count !== 0 || mispredict_count !== 0) begin
            n_err++; $display("FAIL reset_cnt: got f%b %0d %0d want f0 0 0", flush, branch_count,
                              mispredict_count);
        end
    endtask

    task automatic test_sequential();
        pc_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge CLK);
            #1;
            n_vec++;
            if (fetch_pc !== 32'(4 * i) || pred_taken !== 1'b0) begin
                n_err++; $display("FAIL seq_pc[%0d]: got %h/%b want %h/0", i, fetch_pc, pred_taken,
                                  32'(4 * i));
            end
        end
        pc_en = 1'b0;
        n_vec++;
        if (branch_count !== 0 || mispredict_count !== 0) begin
            n_err++; $display("FAIL seq_cnt: got %0d %0d want 0 0", branch_count, mispredict_count);
        end
    endtask

    task automatic test_cold_taken();
        resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        n_vec++;
        if (last_flush !== 1'b1 || fetch_pc !== 32'h100) begin
            n_err++; $display("FAIL cold_redirect: got f%b pc %h want f1 pc 100", last_flush, fetch_pc);
        end
        goto_pc(32'h40);
        n_vec++;
        if (fetch_pc !== 32'h40 || pred_taken !== 1'b1 || pred_target !== 32'h100) begin
            n_err++; $display("FAIL cold_predict: got %h %b %h want 40 1 100", fetch_pc, pred_taken,
                              pred_target);
        end
    endtask

    task automatic test_training();
        for (int i = 0; i < 3; i++) begin
            resolve(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
            n_vec++;
            if (last_flush !== 1'b0 || fetch_pc !== 32'h40) begin
                n_err++; $display("FAIL train_taken[%0d]: got f%b pc %h want f0 pc 40", i, last_flush,
                                  fetch_pc);
            end
        end
        // ctr 3 -> 2, still predicts taken
        resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        n_vec++;
        if (last_flush !== 1'b1 || fetch_pc !== 32'h44) begin
            n_err++; $display("FAIL train_nt1: got f%b pc %h want f1 pc 44", last_flush, fetch_pc);
        end
        goto_pc(32'h40);
        n_vec++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
            n_err++; $display("FAIL train_ctr2: got %b %h want 1 100", pred_taken, pred_target);
        end
        // ctr 2 -> 1, now predicts not-taken
        resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        n_vec++;
        if (last_flush !== 1'b1 || fetch_pc !== 32'h44) begin
            n_err++; $display("FAIL train_nt2: got f%b pc %h want f1 pc 44", last_flush, fetch_pc);
        end
        goto_pc(32'h40);
        n_vec++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_err++; $display("FAIL train_ctr1: got %b %h want 0 44", pred_taken, pred_target);
        end
    endtask

    task automatic test_aliasing();
        resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);   // ctr 1 -> 2
        resolve(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);   // evicts 0x40
        n_vec++;
        if (last_flush !== 1'b1 || fetch_pc !== 32'h200) begin
            n_err++; $display("FAIL alias_redirect: got f%b pc %h want f1 pc 200", last_flush, fetch_pc);
        end
        goto_pc(32'h40);
        n_vec++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_err++; $display("FAIL alias_miss: got %b %h want 0 44", pred_taken, pred_target);
        end
        goto_pc(32'h80);
        n_vec++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            n_err++; $display("FAIL alias_hit: got %b %h want 1 200", pred_taken, pred_target);
        end
    endtask

    task automatic test_target_stall();
        resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);   // re-allocate, ctr 2
        resolve(32'h40, 1'b1, 32'h300, 1'b1, 32'h100);  // target change, pc_en = 0
        n_vec++;
        if (last_flush !== 1'b1 || fetch_pc !== 32'h300) begin
            n_err++; $display("FAIL stall_redirect: got f%b pc %h want f1 pc 300", last_flush, fetch_pc);
        end
        goto_pc(32'h40);
        n_vec++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
            n_err++; $display("FAIL new_target: got %b %h want 1 300", pred_taken, pred_target);
        end
        // Redirect beats a simultaneous predicted advance to 0x300
        pc_en = 1'b1;
        resolve(32'h80, 1'b0, 32'h0, 1'b1, 32'h200);
        pc_en = 1'b0;
        n_vec++;
        if (last_flush !== 1'b1 || fetch_pc !== 32'h84) begin
            n_err++; $display("FAIL redirect_wins: got f%b pc %h want f1 pc 84", last_flush, fetch_pc);
        end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        n_vec++;
        if (fetch_pc !== 32'hFFFF_FFFC || pred_target !== 32'h0) begin
            n_err++; $display("FAIL wrap_target: got %h %h want fffffffc 0", fetch_pc, pred_target);
        end
        pc_en = 1'b1;
        @(posedge CLK);
        #1;
        pc_en = 1'b0;
        n_vec++;
        if (fetch_pc !== 32'h0) begin
            n_err++; $display("FAIL wrap_pc: got %h want 0", fetch_pc);
        end
    endtask

    task automatic test_stats_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 5 || i == 8) begin
                resolve(32'h10, 1'b0, 32'h0, 1'b1, 32'h80);
            end else begin
                resolve(32'h10, 1'b0, 32'h0, 1'b0, 32'h14);
            end
        end
        n_vec++;
        if (branch_count !== 10 || mispredict_count !== 3) begin
            n_err++; $display("FAIL stats: got %0d %0d want 10 3", branch_count, mispredict_count);
        end
        resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        goto_pc(32'h40);
        n_vec++;
        if (pred_taken !== 1'b1 || branch_count !== 12 || mispredict_count !== 5) begin
            n_err++; $display("FAIL pre_reset: got %b %0d %0d want 1 12 5", pred_taken, branch_count,
                              mispredict_count);
        end
        // Reset coincident with a mispredict
        @(negedge CLK);
        RST             = 1'b1;
        res_valid       = 1'b1;
        res_pc          = 32'h80;
        res_taken       = 1'b1;
        res_target      = 32'h200;
        res_pred_taken  = 1'b0;
        res_pred_target = 32'h84;
        #1;
        n_vec++;
        if (flush !== 1'b1) begin
            n_err++; $display("FAIL reset_flush: got %b want 1", flush);
        end
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        res_valid = 1'b0;
        n_vec++;
        if (fetch_pc !== 32'h0 || branch_count !== 0 || mispredict_count !== 0) begin
            n_err++; $display("FAIL midrun_reset: got %h %0d %0d want 0 0 0", fetch_pc, branch_count,
                              mispredict_count);
        end
        goto_pc(32'h40);
        n_vec++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
            n_err++; $display("FAIL cleared_40: got %b %h want 0 44", pred_taken, pred_target);
        end
        goto_pc(32'h80);
        n_vec++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h84) begin
            n_err++; $display("FAIL cleared_80: got %b %h want 0 84", pred_taken, pred_target);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_cold_taken();
        test_training();
        test_aliasing();
        test_target_stall();
        test_wrap();
        test_stats_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised fetch-stage next-PC generator that replaces the plain PC register and PC+4 next-PC selection of the five-stage pipelined datapath. It owns the PC, predicts the next fetch address from a direct-mapped branch target buffer (BTB) with saturating direction counters, and redirects fetch with a flush request when the execute stage resolves a misprediction. It also keeps branch and misprediction statistics counters.

## Interface

Clocking and reset are fixed: one clock, `CLK`; reset `RST` is synchronous and active-high.

Parameters:
- `PC_INIT`, default 0: PC value loaded on reset.
- `ENTRIES`, default 16: BTB entry count. Must be a power of two, ≥ 2. `IDX_W` = log2(`ENTRIES`).
- `CTR_BITS`, default 2: width of each direction counter, 1..4.

Ports:
- `CLK`  in  1  clock
- `RST`  in  1  synchronous active-high reset
- `pc_en`  in  1  fetch may advance (icache hit and not halted)
- `fetch_pc`  out  32  current PC, drives imemaddr
- `pred_taken`  out  1  current fetch predicted taken; travels down the pipeline with the instruction
- `pred_target`  out  32  predicted next PC; travels down the pipeline
- `res_valid`  in  1  execute stage resolves a control instruction this cycle
- `res_pc`  in  32  PC of the resolving instruction
- `res_taken`  in  1  actual direction (jumps always 1)
- `res_target`  in  32  actual taken target
- `res_pred_taken`  in  1  `pred_taken` carried with the instruction
- `res_pred_target`  in  32  `pred_target` carried with the instruction
- `flush`  out  1  squash fetch/decode latches this cycle (combinational)
- `branch_count`  out  32  resolved control instructions
- `mispredict_count`  out  32  mispredictions

## Operation

- PC bits [1:0] are ignored. Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2].
- Each BTB entry holds `valid`, `tag`, a 32-bit `target` and a `CTR_BITS` counter `ctr`.
- Lookup is combinational on `fetch_pc`:
  - hit = valid & tag match.
  - `pred_taken` = hit & ctr MSB.
  - `pred_target` = `pred_taken` ? target : `fetch_pc`+4.
- Mispredict:
  - mispredict = `res_valid` & (`res_taken` != `res_pred_taken` | (`res_taken` & `res_target` != `res_pred_target`)).
  - `flush` = mispredict.
- PC update, in priority order:
  - `RST`: PC ← `PC_INIT`.
  - mispredict: PC ← `res_taken` ? `res_target` : `res_pc`+4. This applies even when `pc_en`=0.
  - `pc_en`: PC ← `pred_target`.
  - Otherwise PC holds.
- BTB update when `res_valid`, at entry index(`res_pc`):
  - Tag hit, taken: ctr increments, saturating at all-ones. target ← `res_target`.
  - Tag hit, not taken: ctr decrements, saturating at 0. target is unchanged.
  - Miss, taken: allocate the entry, overwriting whatever is there. valid←1, tag, target ← `res_target`, ctr ← weakly taken (MSB=1, rest 0).
  - Miss, not taken: no change.
- Statistics:
  - `branch_count` increments on each `res_valid`.
  - `mispredict_count` increments on each mispredict.
  - Both wrap modulo 2^32 and are never cleared except by `RST`.
- Reset:
  - All `valid`←0.
  - All ctr ← weakly not-taken (MSB=0, rest 1; for `CTR_BITS`=1 this is 0).
  - Both counters ← 0.
  - Resulting outputs: `fetch_pc`=`PC_INIT`, `pred_taken`=0, `pred_target`=`PC_INIT`+4, `flush`=0 (flush follows the res_* inputs combinationally).
  - Asserting reset mid-operation discards all BTB state and any in-flight redirect.

## Timing

- Prediction has zero-cycle latency: `pred_*` are valid in the same cycle as `fetch_pc`.
- Redirect:
  - `flush` is asserted in the resolve cycle.
  - `fetch_pc` = corrected PC on the next edge.
- BTB writes take effect on the edge. A lookup in the same cycle as an update to the same index sees the pre-update contents.
- A simultaneous `pc_en` and mispredict follows the mispredict path; the prediction is discarded.
- PC arithmetic is 32-bit. `fetch_pc`+4 wraps at 0xFFFFFFFC → 0x00000000.
- The `res_*` inputs are sampled only when `res_valid`=1. Other values are don't-care.

## Test plan

1. **Reset and sequential fetch.** Pulse `RST`, then hold `pc_en`=1 for 4 cycles with `PC_INIT`=0.
   - `fetch_pc` = 0, 4, 8, 12, 16.
   - `pred_taken`=0 throughout; both counters = 0.
2. **Cold taken branch.** Resolve with `res_pc`=0x40, taken, target 0x100, predicted not-taken.
   - `flush`=1 in that cycle; next `fetch_pc`=0x100.
   - A later fetch at 0x40 gives `pred_taken`=1, `pred_target`=0x100.
3. **Counter training (`CTR_BITS`=2).**
   - Resolve 0x40 taken three times with correct prediction: ctr saturates at 3, and `flush` stays 0 on every one.
   - Then resolve not-taken twice: the first flushes with PC→0x44 and ctr=2; the second (predicted taken) flushes and leaves ctr=1, so fetch at 0x40 now predicts not-taken.
4. **Aliasing (`ENTRIES`=16).** Allocate 0x40, then resolve 0x80 taken to 0x200 (same index, different tag).
   - A fetch at 0x40 misses (`pred_taken`=0).
   - A fetch at 0x80 predicts 0x200.
5. **Target change and stall.**
   - Entry 0x40→0x100 with ctr MSB=1; resolve taken to 0x300 with `pc_en`=0. Require `flush`=1, PC=0x300 next cycle despite the stall, and the entry target now 0x300.
   - Simultaneous `pc_en`=1 plus mispredict: the redirect wins.
6. **Statistics and reset mid-run.**
   - 10 resolutions with 3 mispredictions: `branch_count`=10, `mispredict_count`=3.
   - Assert `RST` in the same cycle as a mispredict. After the edge: PC=`PC_INIT`, counters 0, all predictions not-taken.
